// File: rtl/div_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : div_seq_pkg
// Brief    : Shared widths, status codes and FSM states for the divider
//            request sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package div_seq_pkg;

  localparam int DIVIDEND_W = 32;
  localparam int DIVISOR_W  = 24;
  localparam int QUOTIENT_W = 32;

  localparam logic [1:0] STAT_OK       = 2'd0;
  localparam logic [1:0] STAT_DIV_ZERO = 2'd1;
  localparam logic [1:0] STAT_TIMEOUT  = 2'd2;

  localparam logic [QUOTIENT_W-1:0] QMAX = 32'h7FFF_FFFF;
  localparam logic [QUOTIENT_W-1:0] QMIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Divide-by-zero result saturates toward the sign of the dividend.
  function automatic logic [QUOTIENT_W-1:0] sat_quotient(input logic [DIVIDEND_W-1:0] dividend);
    return dividend[DIVIDEND_W-1] ? QMIN : QMAX;
  endfunction

endpackage
`default_nettype wire

// File: rtl/div_req_fifo.sv
`default_nettype none
// ============================================================================
// Module   : div_req_fifo
// Brief    : Synchronous request FIFO with registered empty and ready flags.
// Revision : 1.0 - initial release
// ============================================================================
module div_req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 60
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_empty,
  output logic             o_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   c_depth   = (AW+1)'(DEPTH);
  localparam logic [AW:0]   c_cnt_one = (AW+1)'(1);
  localparam logic [AW-1:0] c_ptr_one = AW'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             r_empty;
  logic             r_ready;

  logic             w_push;
  logic             w_pop;
  logic [AW:0]      w_count_nxt;

  // r_ready doubles as "not full"; it is low during reset so nothing is pushed.
  assign w_push = i_push & r_ready;
  assign w_pop  = i_pop & ~r_empty;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + c_cnt_one;
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - c_cnt_one;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_empty  <= 1'b1;
      r_ready  <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_one;
      end
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
      r_ready <= (w_count_nxt != c_depth);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_empty = r_empty;
  assign o_ready = r_ready;

endmodule
`default_nettype wire

// File: rtl/div_request_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : div_request_sequencer
// Brief    : Queues divide requests, issues them one at a time to the
//            multi-cycle divider and returns tagged results in order.
// Revision : 1.0 - initial release
// ============================================================================
module div_request_sequencer
  import div_seq_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_s_valid,
  output logic                  o_s_ready,
  input  logic [DIVIDEND_W-1:0] i_s_dividend,
  input  logic [DIVISOR_W-1:0]  i_s_divisor,
  input  logic [TAG_W-1:0]      i_s_tag,
  output logic                  o_div_enable,
  output logic                  o_div_input_valid,
  output logic [DIVIDEND_W-1:0] o_div_dividend,
  output logic [DIVISOR_W-1:0]  o_div_divisor,
  input  logic [QUOTIENT_W-1:0] i_div_quotient,
  input  logic                  i_div_output_valid,
  output logic                  o_m_valid,
  input  logic                  i_m_ready,
  output logic [QUOTIENT_W-1:0] o_m_quotient,
  output logic [TAG_W-1:0]      o_m_tag,
  output logic [1:0]            o_m_status
);

  localparam int ENTRY_W = DIVIDEND_W + DIVISOR_W + TAG_W;
  localparam int CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  state_t                r_state;
  logic [DIVIDEND_W-1:0] r_dividend;
  logic [DIVISOR_W-1:0]  r_divisor;
  logic [TAG_W-1:0]      r_tag;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_div_enable;
  logic                  r_div_input_valid;
  logic                  r_m_valid;
  logic [QUOTIENT_W-1:0] r_m_quotient;
  logic [1:0]            r_m_status;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_empty;
  logic [ENTRY_W-1:0]    w_wdata;
  logic [ENTRY_W-1:0]    w_head;
  logic [DIVIDEND_W-1:0] w_head_dividend;
  logic [DIVISOR_W-1:0]  w_head_divisor;
  logic [TAG_W-1:0]      w_head_tag;

  assign w_push  = i_s_valid & o_s_ready;
  assign w_wdata = {i_s_tag, i_s_divisor, i_s_dividend};
  assign {w_head_tag, w_head_divisor, w_head_dividend} = w_head;

  // The result register is always free in IDLE; in RESP it frees on the handshake.
  assign w_pop = ~w_empty & ((r_state == ST_IDLE) | ((r_state == ST_RESP) & i_m_ready));

  div_req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_wdata),
    .o_rdata (w_head),
    .o_empty (w_empty),
    .o_ready (o_s_ready)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state           <= ST_IDLE;
      r_dividend        <= '0;
      r_divisor         <= '0;
      r_tag             <= '0;
      r_cnt             <= '0;
      r_div_enable      <= 1'b0;
      r_div_input_valid <= 1'b0;
      r_m_valid         <= 1'b0;
      r_m_quotient      <= '0;
      r_m_status        <= STAT_OK;
    end else begin
      r_div_enable      <= 1'b1;
      r_div_input_valid <= 1'b0;

      // The strobe is raised on the pop edge so it lines up with the ISSUE cycle.
      if (w_pop) begin
        r_dividend        <= w_head_dividend;
        r_divisor         <= w_head_divisor;
        r_tag             <= w_head_tag;
        r_div_input_valid <= (w_head_divisor != '0);
      end

      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (r_divisor != '0) begin
            r_cnt   <= '0;
            r_state <= ST_WAIT;
          end else begin
            r_m_quotient <= sat_quotient(r_dividend);
            r_m_status   <= STAT_DIV_ZERO;
            r_m_valid    <= 1'b1;
            r_state      <= ST_RESP;
          end
        end
        ST_WAIT: begin
          if (i_div_output_valid) begin
            r_m_quotient <= i_div_quotient;
            r_m_status   <= STAT_OK;
            r_m_valid    <= 1'b1;
            r_state      <= ST_RESP;
          end else if (r_cnt == c_cnt_last) begin
            r_m_quotient <= '0;
            r_m_status   <= STAT_TIMEOUT;
            r_m_valid    <= 1'b1;
            r_state      <= ST_RESP;
          end else begin
            r_cnt <= r_cnt + c_cnt_one;
          end
        end
        ST_RESP: begin
          if (i_m_ready) begin
            r_m_valid <= 1'b0;
            r_state   <= w_pop ? ST_ISSUE : ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_div_enable      = r_div_enable;
  assign o_div_input_valid = r_div_input_valid;
  assign o_div_dividend    = r_dividend;
  assign o_div_divisor     = r_divisor;
  assign o_m_valid         = r_m_valid;
  assign o_m_quotient      = r_m_quotient;
  assign o_m_tag           = r_tag;
  assign o_m_status        = r_m_status;

endmodule
`default_nettype wire

// File: tb/tb_div_request_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_request_sequencer
// Brief    : Directed self-checking bench with a behavioural divider stub.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_request_sequencer;

  localparam int TAG_W   = 4;
  localparam int TIMEOUT = 64;
  localparam int LAT     = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [31:0]       s_dividend = '0;
  logic [23:0]       s_divisor = '0;
  logic [TAG_W-1:0]  s_tag = '0;
  logic              div_enable;
  logic              div_input_valid;
  logic [31:0]       div_dividend;
  logic [23:0]       div_divisor;
  logic [31:0]       div_quotient = '0;
  logic              div_output_valid = 1'b0;
  logic              m_valid;
  logic              m_ready = 1'b1;
  logic [31:0]       m_quotient;
  logic [TAG_W-1:0]  m_tag;
  logic [1:0]        m_status;

  div_request_sequencer #(
    .DEPTH   (4),
    .TAG_W   (TAG_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .i_s_valid          (s_valid),
    .o_s_ready          (s_ready),
    .i_s_dividend       (s_dividend),
    .i_s_divisor        (s_divisor),
    .i_s_tag            (s_tag),
    .o_div_enable       (div_enable),
    .o_div_input_valid  (div_input_valid),
    .o_div_dividend     (div_dividend),
    .o_div_divisor      (div_divisor),
    .i_div_quotient     (div_quotient),
    .i_div_output_valid (div_output_valid),
    .o_m_valid          (m_valid),
    .i_m_ready          (m_ready),
    .o_m_quotient       (m_quotient),
    .o_m_tag            (m_tag),
    .o_m_status         (m_status)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Divider stub: answers LAT cycles after the strobe; dividend 9 never answers.
  int busy = 0, lat_cnt = 0, pending = 0, strobes = 0, strobe_cyc = 0;
  int stray_req = 0, stray_done = 0;
  always @(negedge clk) begin
    div_output_valid = 1'b0;
    if (!rst_n) begin
      busy = 0;
    end else begin
      if (stray_req != stray_done) begin
        stray_done       = stray_req;
        div_output_valid = 1'b1;
        div_quotient     = 32'h1234;
      end
      if (busy != 0) begin
        if (lat_cnt == 0) begin
          div_output_valid = 1'b1;
          div_quotient     = pending;
          busy             = 0;
        end else begin
          lat_cnt--;
        end
      end
      if (div_input_valid) begin
        check("one_outstanding", busy, 0);
        strobes++;
        strobe_cyc = cyc;
        if (div_dividend != 32'd9) begin
          busy    = 1;
          lat_cnt = LAT;
          pending = $signed(div_dividend) / $signed({{8{div_divisor[23]}}, div_divisor});
        end
      end
    end
  end

  int q_got[$], tag_got[$], stat_got[$], rise_got[$];
  int rise_cyc = 0;
  logic mv_prev = 1'b0;
  always @(negedge clk) begin
    if (m_valid && !mv_prev) rise_cyc = cyc;
    mv_prev = m_valid;
    if (m_valid && m_ready) begin
      q_got.push_back(int'(m_quotient));
      tag_got.push_back(int'(m_tag));
      stat_got.push_back(int'(m_status));
      rise_got.push_back(rise_cyc);
    end
  end

  int acc_cyc = 0;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input int dvd, input int dvs, input int tag);
    logic rdy;
    logic ok;
    ok = 1'b0;
    s_valid    = 1'b1;
    s_dividend = dvd;
    s_divisor  = dvs[23:0];
    s_tag      = tag[TAG_W-1:0];
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      rdy = s_ready;
      @(posedge clk);
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
    s_valid = 1'b0;
    acc_cyc = cyc;
    check("accept", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_results(input int n);
    for (int k = 0; k < 2000; k++) begin
      if (q_got.size() >= n) break;
      @(posedge clk);
      #1;
    end
    check("result_count", q_got.size(), n);
  endtask

  task automatic check_result(input int idx, input int q, input int tag, input int st);
    check("quotient", q_got[idx], q);
    check("tag", tag_got[idx], tag);
    check("status", stat_got[idx], st);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  int s0, c9, n0;
  int exp_q2 [4] = '{-20, -20, 20, 0};

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_s_ready", s_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_div_enable", div_enable, 0);
    check("rst_div_input_valid", div_input_valid, 0);
    check("rst_m_quotient", m_quotient, 0);
    check("rst_div_dividend", div_dividend, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick(2);
    check("div_enable", div_enable, 1);
    check("s_ready_idle", s_ready, 1);

    // Single request 100/5
    send(100, 5, 3);
    wait_results(1);
    check_result(0, 20, 3, 0);
    check("strobe_count_1", strobes, 1);
    check("issue_latency", strobe_cyc - acc_cyc, 1);
    check("result_latency", rise_got[0] - strobe_cyc, LAT + 2);

    // Back-to-back signed requests
    send(-100, 5, 0);
    send(100, -5, 1);
    send(-100, -5, 2);
    send(0, 5, 3);
    wait_results(5);
    for (int i = 0; i < 4; i++) check_result(1 + i, exp_q2[i], i, 0);
    check("strobe_count_2", strobes, 5);

    // Divide by zero, both signs
    s0 = strobes;
    send(7, 0, 5);
    wait_results(6);
    check_result(5, 32'h7FFF_FFFF, 5, 1);
    check("dz_latency_pos", rise_got[5] - acc_cyc, 2);
    send(-7, 0, 6);
    wait_results(7);
    check_result(6, 32'h8000_0000, 6, 1);
    check("dz_latency_neg", rise_got[6] - acc_cyc, 2);
    check("dz_no_strobe", strobes, s0);

    // Hung divider: accept, issue, 64 WAIT cycles, then the timeout result
    send(9, 3, 6);
    c9 = acc_cyc;
    send(40, 4, 7);
    wait_results(9);
    check_result(7, 0, 6, 2);
    check("timeout_latency", rise_got[7] - c9, 66);
    check_result(8, 10, 7, 0);
    check("strobe_count_3", strobes, s0 + 2);

    // Back-pressure on the result stream
    m_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) send(12 * (i + 1), 3, 8 + i);
      end
      begin
        tick(20);
        check("bp_m_valid", m_valid, 1);
        check("bp_quotient", m_quotient, 4);
        check("bp_tag", m_tag, 8);
        check("bp_s_ready", s_ready, 0);
        tick(5);
        check("bp_quotient_hold", m_quotient, 4);
        check("bp_tag_hold", m_tag, 8);
        m_ready = 1'b1;
      end
    join
    wait_results(15);
    for (int i = 0; i < 6; i++) check_result(9 + i, 4 * (i + 1), 8 + i, 0);

    // Reset while waiting on a hung divider with requests queued
    send(9, 3, 1);
    send(20, 5, 2);
    send(30, 5, 3);
    tick(5);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_m_valid", m_valid, 0);
    check("mid_rst_div_input_valid", div_input_valid, 0);
    check("mid_rst_div_enable", div_enable, 0);
    check("mid_rst_s_ready", s_ready, 0);
    check("mid_rst_div_dividend", div_dividend, 0);
    check("mid_rst_m_quotient", m_quotient, 0);
    check("mid_rst_m_tag", m_tag, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    n0 = q_got.size();
    tick(2);
    stray_req++;
    tick(6);
    check("stray_ignored_count", q_got.size(), n0);
    check("stray_ignored_m_valid", m_valid, 0);
    send(50, 5, 4);
    wait_results(n0 + 1);
    check_result(n0, 10, 4, 0);
    tick(10);
    check("queued_discarded", q_got.size(), n0 + 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
